pio_sequencer: RTL and testbench
================================

// Module: pio_sequencer
// PURPOSE
//  Drives the pio action/index/mindex/din command port from a small program ROM and config inputs.
//  On start it loads one PIO machine in a fixed order: program, wrap, divider, pin groups, side-set, enable.
//  After loading it enters RUN and arbitrates a valid/ready byte stream into PUSH actions.
//  It replaces hand-written testbench/SoC action sequences; sits between the host/ROM and the pio.
// PARAMETERS
//  PUSH_GAP  100  min clk cycles from one PUSH action to the next (1..255); paces TX without FIFO status
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  start          in   1   begin load sequence; sampled only in IDLE
//  stop           in   1   in RUN: disable machine and return to IDLE
//  cfg_mindex     in   2   target machine index; captured at start
//  cfg_plen       in   6   program length 0..32; captured at start
//  cfg_div        in   24  clock divider value for DIV action
//  cfg_grps       in   32  pin group word for GRPS action
//  cfg_sides      in   5   side-set bit count for SIDES action
//  prog_addr      out  5   program ROM address; synchronous ROM, data valid 1 cycle later
//  prog_data      in   16  program ROM instruction word
//  push_valid     in   1   requester has push_data
//  push_data      in   32  word to PUSH into the machine TX FIFO
//  push_ready     out  1   combinational: state==RUN && gap counter==0 && !stop
//  action         out  4   pio action code, registered; NONE=0 INSTR=1 PEND=2 DIV=7 GRPS=5 SIDES=8 EN=6 PUSH=4 APULL=11
//  index          out  5   instruction slot, registered
//  mindex         out  2   machine index, registered
//  din            out  32  action data, registered
//  busy           out  1   high from start accept until return to IDLE or RUN
//  done           out  1   one-cycle pulse the cycle after the EN(1) action
// BEHAVIOUR
//  Reset: all outputs 0 (action=NONE), state IDLE, gap counter 0, captured cfg cleared.
//  Every non-NONE action is exactly one cycle; action returns to NONE the following cycle.
//  States: IDLE, FETCH, INSTR, PEND, DIV, GRPS, SIDES, [APULL], EN, RUN, STOP.
//  IDLE: start -> capture mindex/plen, i=0, busy=1; -> FETCH if plen!=0 else -> PEND.
//  FETCH: prog_addr=i, action=NONE; -> INSTR.
//  INSTR: action=INSTR, index=i, din={16'h0,prog_data}; i==plen-1 -> PEND else i++ -> FETCH.
//  Load timing: 2 cycles per instruction; total load = 2*plen+5 cycles (+1 with APULL) start->EN.
//  PEND: din = plen-1 (6-bit result zero-extended), din=0 when plen==0.
//  DIV/GRPS/SIDES: din = zero-extended cfg_div/cfg_grps/cfg_sides.
//  EN: din=1; next cycle done=1, busy=0, -> RUN.
//  RUN: push_valid&&push_ready -> next cycle action=PUSH, din=push_data, gap counter=PUSH_GAP-1.
//  Gap counter decrements to 0 each cycle; push_ready low while nonzero.
//  RUN+stop: -> STOP (stop has priority over a same-cycle push; no PUSH issued).
//  STOP: action=EN, din=0; -> IDLE.
//  mindex output holds captured value for all actions.
//  start while busy or in RUN: ignored. cfg_* other than mindex/plen read live at their action cycle.
//  Async reset mid-sequence: action drops to NONE immediately; machine left partially loaded.
// CONFIGURATION
//  PIOSEQ_APULL_EN defined: adds input cfg_pull_thresh[5:0]; APULL state between SIDES and EN,
//   action=APULL, din={26'h0,cfg_pull_thresh}; load = 2*plen+6 cycles.
//  Not defined: no port, no APULL state; SIDES -> EN directly.
// TESTING
//  plen=4, ROM 0..3, start 1 cycle -> INSTR idx 0..3 alternating with NONE, then PEND 3, DIV, GRPS, SIDES, EN 1; done at cycle 14.
//  plen=0, start -> no INSTR; PEND din=0 is first action; done 6 cycles after start.
//  RUN, PUSH_GAP=4, push_valid held with 'h30,'h31 -> PUSH 'h30, 'h31 exactly 4 cycles apart.
//  Start pulsed during load and in RUN -> no restart, action trace unchanged.
//  RUN with push_valid and stop same cycle -> no PUSH; EN din=0; IDLE; push_ready=0.
//  Reset asserted mid-INSTR -> action=NONE, busy=0 asynchronously; new start reloads from idx 0.

Source files
------------

// File: rtl/pio_sequencer_if.sv
// pio_sequencer_if
//   Bundles the two buses of the sequencer:
//     - the push byte/word stream (push_valid, push_data, push_ready)
//     - the pio command port     (action, index, mindex, din)
//   master : sequencer side (drives command port and push_ready)
//   slave  : environment side (drives push_valid/push_data, observes the rest)
interface pio_sequencer_if;
    logic        push_valid;
    logic [31:0] push_data;
    logic        push_ready;
    logic [3:0]  action;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic [31:0] din;

    modport master (
        input  push_valid, push_data,
        output push_ready, action, index, mindex, din
    );

    modport slave (
        output push_valid, push_data,
        input  push_ready, action, index, mindex, din
    );
endinterface

// File: rtl/pio_sequencer.sv
// pio_sequencer
//   Loads one PIO machine from a program ROM and config inputs
//   (program, wrap, divider, pin groups, side-set, [autopull], enable),
//   then runs a paced valid/ready push stream into PUSH actions.
//   Optional feature macro: PIOSEQ_APULL_EN adds cfg_pull_thresh and an
//   APULL action between SIDES and EN.
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   start, stop      begin load (IDLE only) / leave RUN
//   cfg_*            machine index/program length (captured at start),
//                    divider/groups/side-set (read live at their action)
//   prog_addr/data   synchronous program ROM (1-cycle read latency)
//   busy, done       load in progress / one-cycle pulse after EN(1)
//   bus (master)     push stream and registered pio command port
module pio_sequencer #(
    parameter int unsigned PUSH_GAP = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  cfg_mindex,
    input  logic [5:0]  cfg_plen,
    input  logic [23:0] cfg_div,
    input  logic [31:0] cfg_grps,
    input  logic [4:0]  cfg_sides,
`ifdef PIOSEQ_APULL_EN
    input  logic [5:0]  cfg_pull_thresh,
`endif
    output logic [4:0]  prog_addr,
    input  logic [15:0] prog_data,
    output logic        busy,
    output logic        done,
    pio_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        ACT_NONE  = 4'd0,
        ACT_INSTR = 4'd1,
        ACT_PEND  = 4'd2,
        ACT_PUSH  = 4'd4,
        ACT_GRPS  = 4'd5,
        ACT_EN    = 4'd6,
        ACT_DIV   = 4'd7,
        ACT_SIDES = 4'd8,
        ACT_APULL = 4'd11
    } action_e;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_INSTR, S_PEND, S_DIV, S_GRPS, S_SIDES, S_EN, S_RUN, S_STOP
`ifdef PIOSEQ_APULL_EN
        , S_APULL
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  i_q, i_d;
    logic [5:0]  plen_q, plen_d;
    logic [1:0]  mindex_q, mindex_d;
    logic [7:0]  gap_q, gap_d;
    action_e     act_q, act_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] din_q, din_d;
    logic        done_q, done_d;
    logic        push_ready;

    assign push_ready = (state_q == S_RUN) && (gap_q == '0) && !stop;

    // The ROM address runs one slot ahead during INSTR (and sits at 0 in IDLE),
    // so the word is already on prog_data in FETCH and the INSTR action can be
    // registered into the INSTR cycle itself.
    assign prog_addr = (state_q == S_INSTR) ? i_q + 5'd1 : i_q;

    assign busy = !(state_q inside {S_IDLE, S_RUN, S_STOP});
    assign done = done_q;

    assign bus.push_ready = push_ready;
    assign bus.action     = act_q;
    assign bus.index      = idx_q;
    assign bus.mindex     = mindex_q;
    assign bus.din        = din_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            plen_q   <= '0;
            mindex_q <= '0;
            gap_q    <= '0;
            act_q    <= ACT_NONE;
            idx_q    <= '0;
            din_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            plen_q   <= plen_d;
            mindex_q <= mindex_d;
            gap_q    <= gap_d;
            act_q    <= act_d;
            idx_q    <= idx_d;
            din_q    <= din_d;
            done_q   <= done_d;
        end
    end

    // Next state plus the action to present during that next state.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        plen_d   = plen_q;
        mindex_d = mindex_q;
        gap_d    = (gap_q != '0) ? gap_q - 8'd1 : gap_q;
        act_d    = ACT_NONE;
        idx_d    = '0;
        din_d    = '0;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mindex_d = cfg_mindex;
                    plen_d   = cfg_plen;
                    i_d      = '0;
                    if (cfg_plen != '0) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_PEND;
                        act_d   = ACT_PEND;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_INSTR;
                act_d   = ACT_INSTR;
                idx_d   = i_q;
                din_d   = {16'h0, prog_data};
            end
            S_INSTR: begin
                // slot 31 also ends the program so an oversized plen cannot spin
                if (({1'b0, i_q} == plen_q - 6'd1) || (i_q == 5'd31)) begin
                    state_d = S_PEND;
                    i_d     = '0;
                    act_d   = ACT_PEND;
                    din_d   = {26'h0, plen_q - 6'd1};
                end else begin
                    state_d = S_FETCH;
                    i_d     = i_q + 5'd1;
                end
            end
            S_PEND: begin
                state_d = S_DIV;
                act_d   = ACT_DIV;
                din_d   = {8'h0, cfg_div};
            end
            S_DIV: begin
                state_d = S_GRPS;
                act_d   = ACT_GRPS;
                din_d   = cfg_grps;
            end
            S_GRPS: begin
                state_d = S_SIDES;
                act_d   = ACT_SIDES;
                din_d   = {27'h0, cfg_sides};
            end
`ifdef PIOSEQ_APULL_EN
            S_SIDES: begin
                state_d = S_APULL;
                act_d   = ACT_APULL;
                din_d   = {26'h0, cfg_pull_thresh};
            end
            S_APULL: begin
                state_d = S_EN;
                act_d   = ACT_EN;
                din_d   = 32'd1;
            end
`else
            S_SIDES: begin
                state_d = S_EN;
                act_d   = ACT_EN;
                din_d   = 32'd1;
            end
`endif
            S_EN: begin
                state_d = S_RUN;
                done_d  = 1'b1;
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_STOP;
                    act_d   = ACT_EN;
                    din_d   = '0;
                end else if (bus.push_valid && push_ready) begin
                    act_d = ACT_PUSH;
                    din_d = bus.push_data;
                    gap_d = 8'(PUSH_GAP - 1);
                end
            end
            S_STOP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pio_sequencer.sv
// tb_pio_sequencer
//   Random and directed stimulus for pio_sequencer with a queue-based
//   reference model of the expected command trace, compared every cycle.
module tb_pio_sequencer;

    localparam int unsigned TB_GAP = 4;
`ifdef PIOSEQ_APULL_EN
    localparam int APX = 1;
`else
    localparam int APX = 0;
`endif

    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_STOP = 3;
    localparam int K_FETCH = 0, K_INSTR = 1, K_PEND = 2, K_DIV = 3,
                   K_GRPS = 4, K_SIDES = 5, K_APULL = 6, K_EN = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  cfg_mindex = '0;
    logic [5:0]  cfg_plen = '0;
    logic [23:0] cfg_div = 24'h123456;
    logic [31:0] cfg_grps = 32'hCAFE_0042;
    logic [4:0]  cfg_sides = 5'd3;
    logic [5:0]  cfg_pull_thresh = 6'd17;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data = '0;
    logic        busy;
    logic        done;
    logic [15:0] rom [0:31];

    int vectors = 0;
    int miscompares = 0;

    pio_sequencer_if bus_if ();

    pio_sequencer #(.PUSH_GAP(TB_GAP)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .cfg_mindex(cfg_mindex),
        .cfg_plen(cfg_plen),
        .cfg_div(cfg_div),
        .cfg_grps(cfg_grps),
        .cfg_sides(cfg_sides),
`ifdef PIOSEQ_APULL_EN
        .cfg_pull_thresh(cfg_pull_thresh),
`endif
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .busy(busy),
        .done(done),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    // synchronous program ROM
    always @(posedge clk) prog_data <= rom[prog_addr];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int kind; int k; } ent_t;
    ent_t tq[$];
    int   phase = PH_IDLE;
    int   cyc = 0;
    int   last_push = -1000;
    int   m_act = 0;
    int   m_idx = 0;
    logic [31:0] m_din = '0;
    int   m_done = 0;
    int   m_mindex = 0;
    int   m_addr_chk = 0;
    int   m_addr = 0;

    task automatic pop_entry();
        ent_t e;
        e = tq.pop_front();
        case (e.kind)
            K_FETCH: begin m_addr_chk = 1; m_addr = e.k; end
            K_INSTR: begin m_act = 1; m_idx = e.k; m_din = {16'h0, rom[e.k]}; end
            K_PEND:  begin m_act = 2; m_din = 32'(e.k); end
            K_DIV:   begin m_act = 7; m_din = {8'h0, cfg_div}; end
            K_GRPS:  begin m_act = 5; m_din = cfg_grps; end
            K_SIDES: begin m_act = 8; m_din = {27'h0, cfg_sides}; end
            K_APULL: begin m_act = 11; m_din = {26'h0, cfg_pull_thresh}; end
            default: begin m_act = 6; m_din = 32'd1; end
        endcase
    endtask

    task automatic model_step();
        int plen_c;
        m_act = 0; m_idx = 0; m_din = '0; m_done = 0; m_addr_chk = 0;
        case (phase)
            PH_IDLE: if (start) begin
                m_mindex = int'(cfg_mindex);
                plen_c   = int'(cfg_plen);
                for (int k = 0; k < plen_c; k++) begin
                    tq.push_back('{K_FETCH, k});
                    tq.push_back('{K_INSTR, k});
                end
                tq.push_back('{K_PEND, (plen_c == 0) ? 0 : plen_c - 1});
                tq.push_back('{K_DIV, 0});
                tq.push_back('{K_GRPS, 0});
                tq.push_back('{K_SIDES, 0});
                if (APX != 0) tq.push_back('{K_APULL, 0});
                tq.push_back('{K_EN, 0});
                phase = PH_LOAD;
                pop_entry();
            end
            PH_LOAD: begin
                if (tq.size() == 0) begin
                    m_done = 1;
                    phase  = PH_RUN;
                end else begin
                    pop_entry();
                end
            end
            PH_RUN: begin
                if (stop) begin
                    m_act = 6; m_din = '0;
                    phase = PH_STOP;
                end else if (bus_if.push_valid && (cyc - last_push >= int'(TB_GAP) - 1)) begin
                    m_act = 4; m_din = bus_if.push_data;
                    last_push = cyc + 1;
                end
            end
            default: phase = PH_IDLE;
        endcase
        cyc++;
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            phase = PH_IDLE; tq.delete();
            m_act = 0; m_idx = 0; m_din = '0; m_done = 0; m_mindex = 0;
            m_addr_chk = 0; last_push = -1000;
        end else begin
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        chk("action", 32'(bus_if.action), 32'(m_act));
        chk("mindex", 32'(bus_if.mindex), 32'(m_mindex));
        chk("busy", 32'(busy), 32'(phase == PH_LOAD));
        chk("done", 32'(done), 32'(m_done));
        chk("push_ready", 32'(bus_if.push_ready),
            32'((phase == PH_RUN) && (cyc - last_push >= int'(TB_GAP) - 1) && !stop));
        if (m_addr_chk != 0) chk("prog_addr", 32'(prog_addr), 32'(m_addr));
        if (m_act == 1) chk("index", 32'(bus_if.index), 32'(m_idx));
        if (m_act != 0) chk("din", bus_if.din, m_din);
    end

    // ---------------- directed + random stimulus ----------------
    logic [3:0]  tr_act [0:80];
    logic [31:0] tr_din [0:80];
    logic [4:0]  tr_idx [0:80];

    task automatic start_and_wait(input logic [5:0] plen, input logic [1:0] mi,
                                  input int poke_at, output int done_n);
        @(posedge clk); #2;
        cfg_plen = plen; cfg_mindex = mi; start = 1'b1;
        done_n = -1;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            tr_act[n] = bus_if.action; tr_din[n] = bus_if.din; tr_idx[n] = bus_if.index;
            if (done) begin done_n = n; break; end
            #1; start = (n == poke_at);
        end
        #1; start = 1'b0;
    endtask

    task automatic do_stop();
        @(posedge clk); #2; stop = 1'b1;
        @(posedge clk); #2; stop = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int exp_acts[$];
        int done_n, got;
        int pc[2];
        logic [31:0] pd[2];

        for (int k = 0; k < 32; k++) rom[k] = 16'($urandom);
        for (int k = 0; k < 4; k++) rom[k] = 16'hA000 + 16'(k);
        bus_if.push_valid = 1'b0;
        bus_if.push_data  = '0;

        // reset state
        #1;
        chk("rst_action", 32'(bus_if.action), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(bus_if.push_ready), 32'd0);
        repeat (2) @(posedge clk);
        #2; reset = 1'b0;

        // plen=4 load with a start poke during the load
        start_and_wait(6'd4, 2'd2, 5, done_n);
        if (APX != 0) exp_acts = '{0,1,0,1,0,1,0,1,2,7,5,8,11,6};
        else          exp_acts = '{0,1,0,1,0,1,0,1,2,7,5,8,6};
        for (int n = 1; n <= exp_acts.size(); n++) chk("trace_act", 32'(tr_act[n]), 32'(exp_acts[n-1]));
        for (int k = 0; k < 4; k++) begin
            chk("trace_instr_din", tr_din[2+2*k], 32'hA000 + 32'(k));
            chk("trace_instr_idx", 32'(tr_idx[2+2*k]), 32'(k));
        end
        chk("trace_pend_din", tr_din[9], 32'd3);
        chk("trace_en_din", tr_din[13+APX], 32'd1);
        chk("done_cycle_plen4", 32'(done_n), 32'(14 + APX));

        // push pacing, with a start pulse while in RUN
        @(posedge clk); #2;
        bus_if.push_data = 32'h30; bus_if.push_valid = 1'b1; start = 1'b1;
        got = 0; pc[0] = -1; pc[1] = -100; pd[0] = '0; pd[1] = '0;
        for (int n = 1; n <= 60 && got < 2; n++) begin
            @(posedge clk); #1;
            if (n == 1) chk("start_in_run_busy", 32'(busy), 32'd0);
            if (bus_if.action == 4'd4) begin pc[got] = n; pd[got] = bus_if.din; got++; end
            #1; start = 1'b0;
            if (got == 1) bus_if.push_data = 32'h31;
            if (got >= 2) bus_if.push_valid = 1'b0;
        end
        bus_if.push_valid = 1'b0;
        chk("push_count", 32'(got), 32'd2);
        chk("push0_din", pd[0], 32'h30);
        chk("push1_din", pd[1], 32'h31);
        chk("push_spacing", 32'(pc[1] - pc[0]), 32'(TB_GAP));

        // stop beats a same-cycle push
        repeat (6) @(posedge clk);
        #2; bus_if.push_valid = 1'b1; bus_if.push_data = 32'h55; stop = 1'b1;
        #2; chk("stop_ready", 32'(bus_if.push_ready), 32'd0);
        @(posedge clk); #1;
        chk("stop_action", 32'(bus_if.action), 32'd6);
        chk("stop_din", bus_if.din, 32'd0);
        #1; stop = 1'b0; bus_if.push_valid = 1'b0;
        @(posedge clk); #1;
        chk("after_stop_action", 32'(bus_if.action), 32'd0);
        chk("after_stop_busy", 32'(busy), 32'd0);
        chk("after_stop_ready", 32'(bus_if.push_ready), 32'd0);

        // empty program
        start_and_wait(6'd0, 2'd1, 0, done_n);
        chk("plen0_first_act", 32'(tr_act[1]), 32'd2);
        chk("plen0_pend_din", tr_din[1], 32'd0);
        chk("done_cycle_plen0", 32'(done_n), 32'(6 + APX));
        do_stop();

        // asynchronous reset in the middle of the program load
        @(posedge clk); #2; cfg_plen = 6'd8; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_instr", 32'(bus_if.action), 32'd1);
        #1; reset = 1'b1;
        #1;
        chk("async_rst_action", 32'(bus_if.action), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #2; reset = 1'b0;
        start_and_wait(6'd2, 2'd3, 0, done_n);
        chk("reload_act", 32'(tr_act[2]), 32'd1);
        chk("reload_idx", 32'(tr_idx[2]), 32'd0);
        chk("reload_din", tr_din[2], {16'h0, rom[0]});
        chk("done_cycle_plen2", 32'(done_n), 32'(10 + APX));

        // randomized traffic, with occasional resets
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #2;
            reset              = ($urandom % 400 == 0);
            start              = ($urandom % 12 == 0);
            stop               = ($urandom % 60 == 0);
            bus_if.push_valid  = 1'($urandom % 2);
            bus_if.push_data   = $urandom;
            cfg_mindex         = 2'($urandom);
            cfg_plen           = 6'($urandom_range(0, 32));
            cfg_div            = 24'($urandom);
            cfg_grps           = $urandom;
            cfg_sides          = 5'($urandom);
            cfg_pull_thresh    = 6'($urandom);
        end
        @(posedge clk); #2;
        reset = 1'b0; start = 1'b0; stop = 1'b0; bus_if.push_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
